// File: rtl/rgb_led_arb_pkg.sv
// Shared types and helpers for the RGB LED arbiter.
// The rgb_t struct is sized at the default PWM width.
package rgb_led_arb_pkg;

    localparam int unsigned PwmBitsDef = 8;

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StGap
    } arb_state_e;

    typedef struct packed {
        logic [PwmBitsDef-1:0] r;
        logic [PwmBitsDef-1:0] g;
        logic [PwmBitsDef-1:0] b;
    } rgb_t;

    function automatic int unsigned hold_cyc(input int unsigned clk_hz,
                                             input int unsigned hold_ms);
        return clk_hz / 1000 * hold_ms;
    endfunction

    function automatic int unsigned blink_cyc(input int unsigned clk_hz,
                                              input int unsigned blink_ms);
        return clk_hz / 1000 * blink_ms;
    endfunction

endpackage

// File: rtl/rgb_led_arb_if.sv
// Request/colour/grant bundle between status sources and the LED arbiter.
interface rgb_led_arb_if
    import rgb_led_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned PWM_BITS = PwmBitsDef
);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*3*PWM_BITS-1:0] color;
    logic [NUM_REQ-1:0]            blink;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;

    modport master (output req, output color, output blink, input grant, input busy);
    modport slave  (input req, input color, input blink, output grant, output busy);

endinterface

// File: rtl/led_pwm.sv
// PWM generator with blink/enable gating and registered active-low outputs.
// Optional gamma correction when RGB_LED_ARB_GAMMA_EN is defined.
module led_pwm
    import rgb_led_arb_pkg::*;
#(
    parameter int unsigned PWM_BITS = PwmBitsDef
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic [PWM_BITS-1:0] duty_r_i,
    input  logic [PWM_BITS-1:0] duty_g_i,
    input  logic [PWM_BITS-1:0] duty_b_i,
    output logic                led_r_n_o,
    output logic                led_g_n_o,
    output logic                led_b_n_o
);

    logic [PWM_BITS-1:0] pc_q;
    logic [PWM_BITS-1:0] eff_r, eff_g, eff_b;

    function automatic logic [PWM_BITS-1:0] eff_duty(input logic [PWM_BITS-1:0] d);
`ifdef RGB_LED_ARB_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
        return sq[2*PWM_BITS-1:PWM_BITS];
`else
        return d;
`endif
    endfunction

    always_comb begin
        eff_r = eff_duty(duty_r_i);
        eff_g = eff_duty(duty_g_i);
        eff_b = eff_duty(duty_b_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            led_r_n_o <= 1'b1;
            led_g_n_o <= 1'b1;
            led_b_n_o <= 1'b1;
        end else begin
            pc_q      <= pc_q + 1'b1;
            led_r_n_o <= ~(en_i && (pc_q < eff_r));
            led_g_n_o <= ~(en_i && (pc_q < eff_g));
            led_b_n_o <= ~(en_i && (pc_q < eff_b));
        end
    end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin arbiter sharing one active-low RGB LED among NUM_REQ status sources.
// Define RGB_LED_ARB_GAMMA_EN for quadratic gamma on the PWM duty.
module rgb_led_arbiter
    import rgb_led_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned CLK_HZ   = 12000000,
    parameter int unsigned HOLD_MS  = 250,
    parameter int unsigned BLINK_MS = 250,
    parameter int unsigned PWM_BITS = PwmBitsDef
) (
    input  logic        clk,
    input  logic        rst_n,
    rgb_led_arb_if.slave bus,
    output logic        led_red_n,
    output logic        led_grn_n,
    output logic        led_blu_n
);

    localparam int unsigned HoldCyc  = hold_cyc(CLK_HZ, HOLD_MS);
    localparam int unsigned BlinkCyc = blink_cyc(CLK_HZ, BLINK_MS);
    localparam int unsigned HoldW    = $clog2(HoldCyc + 1);
    localparam int unsigned BlinkW   = $clog2(BlinkCyc + 1);
    localparam int unsigned IdxW     = $clog2(NUM_REQ);

    arb_state_e           state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 busy_q;
    logic                 phase_q;
    logic [IdxW-1:0]      gidx_q;
    logic [IdxW-1:0]      last_q;
    logic [HoldW-1:0]     hold_q;
    logic [BlinkW-1:0]    bcnt_q;

    logic [IdxW-1:0]      win_idx;
    logic [IdxW-1:0]      cidx;
    logic                 found;
    int unsigned          cand;
    logic                 others_pending;
    logic                 blink_sel;
    rgb_t                 sel_rgb;

    // Search starts just after the last released slot, so it is considered last.
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        cidx    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(last_q) + off) % NUM_REQ;
            cidx = IdxW'(cand);
            if (!found && bus.req[cidx]) begin
                found   = 1'b1;
                win_idx = cidx;
            end
        end
    end

    assign others_pending = |(bus.req & ~grant_q);
    assign blink_sel      = bus.blink[gidx_q];
    assign sel_rgb        = bus.color[32'(gidx_q)*3*PWM_BITS +: 3*PWM_BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            busy_q  <= 1'b0;
            phase_q <= 1'b0;
            gidx_q  <= '0;
            last_q  <= IdxW'(NUM_REQ - 1);
            hold_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            case (state_q)
                StShow: begin
                    if (!bus.req[gidx_q] || (hold_q == '0 && others_pending)) begin
                        state_q <= StGap;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        last_q  <= gidx_q;
                    end else begin
                        if (hold_q != '0) hold_q <= hold_q - 1'b1;
                        if (blink_sel) begin
                            if (bcnt_q == BlinkW'(BlinkCyc - 1)) begin
                                bcnt_q  <= '0;
                                phase_q <= ~phase_q;
                            end else begin
                                bcnt_q <= bcnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    // IDLE and GAP both start a new grant when anything is pending.
                    if (|bus.req) begin
                        state_q <= StShow;
                        grant_q <= NUM_REQ'(1) << win_idx;
                        gidx_q  <= win_idx;
                        busy_q  <= 1'b1;
                        hold_q  <= HoldW'(HoldCyc - 1);
                        bcnt_q  <= '0;
                        phase_q <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;

    led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_led_pwm (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (busy_q & phase_q),
        .duty_r_i  (sel_rgb.r),
        .duty_g_i  (sel_rgb.g),
        .duty_b_i  (sel_rgb.b),
        .led_r_n_o (led_red_n),
        .led_g_n_o (led_grn_n),
        .led_b_n_o (led_blu_n)
    );

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed bench for rgb_led_arbiter: HOLD_CYC=4, BLINK_CYC=2.
module tb_rgb_led_arbiter;

    localparam int unsigned NReq = 4;
    localparam int unsigned Pw   = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic led_red_n, led_grn_n, led_blu_n;
    int   n_checks = 0;
    int   n_errors = 0;

    rgb_led_arb_if #(.NUM_REQ(NReq), .PWM_BITS(Pw)) bus ();

    rgb_led_arbiter #(
        .NUM_REQ  (NReq),
        .CLK_HZ   (1000),
        .HOLD_MS  (4),
        .BLINK_MS (2),
        .PWM_BITS (Pw)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .led_red_n (led_red_n),
        .led_grn_n (led_grn_n),
        .led_blu_n (led_blu_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        bus.req   = '0;
        bus.blink = '0;
        bus.color = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_color(input int idx, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b);
        bus.color[idx*24 +: 24] = {r, g, b};
    endtask

    task automatic count_low(input int n, output int r, output int g, output int b);
        r = 0; g = 0; b = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (!led_red_n) r++;
            if (!led_grn_n) g++;
            if (!led_blu_n) b++;
        end
    endtask

    initial begin
        int r, g, b, bad;
        logic [3:0] exp_g;
        logic exp4 [6];
        exp4 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state, with a request held so reset dominance is visible.
        rst_n     = 1'b0;
        bus.req   = 4'b1111;
        bus.blink = '0;
        bus.color = '1;
        step();
        step();
        check("rst_grant", bus.grant, 4'b0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_leds", {led_red_n, led_grn_n, led_blu_n}, 3'b111);

        // 1: single requester, red 255, held indefinitely.
        apply_reset();
        set_color(0, 8'd255, 8'd0, 8'd0);
        bus.req = 4'b0001;
        step();
        check("t1_grant", bus.grant, 4'b0001);
        check("t1_busy", bus.busy, 1'b1);
        check("t1_led_latency", led_red_n, 1'b1);
        step();
        check("t1_led_first", led_red_n, 1'b0);
        r = 0; g = 0; b = 0; bad = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (!led_red_n) r++;
            if (!led_grn_n) g++;
            if (!led_blu_n) b++;
            if (bus.grant !== 4'b0001) bad++;
        end
        check("t1_red_low", r, 255);
        check("t1_grn_low", g, 0);
        check("t1_blu_low", b, 0);
        check("t1_grant_held", bad, 0);

        // 2: round-robin with all requesting.
        apply_reset();
        bus.req = 4'b1111;
        for (int n = 1; n <= 24; n++) begin
            step();
            exp_g = ((n - 1) % 5 == 4) ? 4'b0000 : (4'b0001 << (((n - 1) / 5) % 4));
            check($sformatf("t2_grant_%0d", n), bus.grant, exp_g);
            check($sformatf("t2_busy_%0d", n), bus.busy, |exp_g);
        end

        // 3: early drop of requester 0 while requester 2 waits.
        apply_reset();
        bus.req = 4'b0101;
        step();
        check("t3_grant_a", bus.grant, 4'b0001);
        step();
        check("t3_grant_b", bus.grant, 4'b0001);
        bus.req = 4'b0100;
        step();
        check("t3_gap", bus.grant, 4'b0000);
        step();
        check("t3_grant_c", bus.grant, 4'b0100);
        step();
        check("t3_grant_d", bus.grant, 4'b0100);

        // 4: blink on requester 1, phase restarts ON on a new grant.
        apply_reset();
        set_color(1, 8'd255, 8'd255, 8'd255);
        bus.blink = 4'b0010;
        bus.req   = 4'b0010;
        step();
        check("t4_grant", bus.grant, 4'b0010);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("t4_blink_%0d", i), {led_red_n, led_grn_n, led_blu_n},
                  {3{exp4[i]}});
        end
        bus.req = 4'b0000;
        step();
        check("t4_gap_grant", bus.grant, 4'b0000);
        check("t4_gap_leds", {led_red_n, led_grn_n, led_blu_n}, 3'b111);
        bus.req = 4'b0010;
        step();
        check("t4_regrant", bus.grant, 4'b0010);
        check("t4_regrant_leds", {led_red_n, led_grn_n, led_blu_n}, 3'b111);
        step();
        check("t4_restart_on_a", {led_red_n, led_grn_n, led_blu_n}, 3'b000);
        step();
        check("t4_restart_on_b", {led_red_n, led_grn_n, led_blu_n}, 3'b000);
        step();
        check("t4_restart_off", {led_red_n, led_grn_n, led_blu_n}, 3'b111);

        // 5: asynchronous reset in the middle of grant 0100.
        apply_reset();
        for (int i = 0; i < 4; i++) set_color(i, 8'd0, 8'd255, 8'd0);
        bus.req = 4'b1111;
        for (int i = 0; i < 12; i++) step();
        check("t5_pre_grant", bus.grant, 4'b0100);
        check("t5_pre_grn", led_grn_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_grant", bus.grant, 4'b0000);
        check("t5_async_busy", bus.busy, 1'b0);
        check("t5_async_leds", {led_red_n, led_grn_n, led_blu_n}, 3'b111);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t5_first_after", bus.grant, 4'b0001);

        // 6: duty shaping (gamma or linear, depending on the build).
        apply_reset();
        set_color(0, 8'd128, 8'd15, 8'd255);
        bus.req = 4'b0001;
        step();
        step();
        count_low(256, r, g, b);
`ifdef RGB_LED_ARB_GAMMA_EN
        check("t6_red_128", r, 64);
        check("t6_grn_15", g, 0);
        check("t6_blu_255", b, 254);
`else
        check("t6_red_128", r, 128);
        check("t6_grn_15", g, 15);
        check("t6_blu_255", b, 255);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

Shares the board's single active-low RGB LED (LED_RED_N / LED_GRN_N / LED_BLU_N) among several internal status requesters. It uses round-robin arbitration with a guaranteed minimum display time, optional per-requester blinking, and 8-bit-per-channel PWM colour. It sits between status sources (UART activity, heartbeat, error flags, button state) and the top-level LED pins, in the `clk` domain.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `CLK_HZ`, default 12000000: frequency of `clk`.
- `HOLD_MS`, default 250: minimum display time per grant.
- `BLINK_MS`, default 250: blink half-period.
- `PWM_BITS`, default 8: duty and PWM counter width.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req`, in, NUM_REQ: request vector, level-sensitive.
- `color`, in, NUM_REQ*3*PWM_BITS: per-requester {R,G,B} duty; requester i occupies bits [i*24 +: 24] at default width.
- `blink`, in, NUM_REQ: per-requester blink enable.
- `grant`, out, NUM_REQ: one-hot grant, all-zero when idle.
- `busy`, out, 1: high in SHOW.
- `led_red_n`, out, 1: active-low red LED.
- `led_grn_n`, out, 1: active-low green LED.
- `led_blu_n`, out, 1: active-low blue LED.

## Operation
- Derived constants:
  - HOLD_CYC = CLK_HZ/1000*HOLD_MS.
  - BLINK_CYC = CLK_HZ/1000*BLINK_MS.
  - Both must be at least 1.
  - Counter widths are $clog2(X+1).
- State machine has three states: IDLE, SHOW, GAP.
- IDLE:
  - grant = 0, LEDs dark.
  - Any `req` bit high moves to SHOW and registers the round-robin winner into `grant`.
- Round-robin winner: search starts at index `last+1` and wraps modulo NUM_REQ. `last` resets to NUM_REQ-1, so requester 0 wins first after reset.
- SHOW:
  - Hold counter loads HOLD_CYC-1 on entry and decrements to 0, then saturates.
  - Blink counter and blink phase reset on entry, with the phase starting ON.
  - Granted `req` drops, at any time: go to GAP.
  - Hold counter = 0 and another `req` bit is high: go to GAP and update `last`.
  - Hold counter = 0 and only the granted requester is pending: stay in SHOW indefinitely, with no re-arbitration.
- GAP:
  - Lasts exactly one cycle. grant = 0 and LEDs dark.
  - Then goes to SHOW with a new winner if any `req` is high, else to IDLE.
  - The requester just released is eligible only if no other requester is pending.
- PWM:
  - Free-running PWM_BITS counter `pc`, wrapping at 2^PWM_BITS-1 → 0.
  - A channel is on when `pc` < duty. Duty 0 is always off; duty 255 is on for 255 of 256 cycles.
- Blink:
  - When the granted `blink` bit is high, the phase toggles every BLINK_CYC cycles.
  - Phase OFF forces all three channels off.
  - `blink` and `color` are sampled live every cycle from the granted slot.
- LED outputs are registered and inverted: `led_x_n` = ~on.
- Reset values:
  - state = IDLE, grant = 0, busy = 0.
  - `led_red_n` = `led_grn_n` = `led_blu_n` = 1.
  - pc = 0, last = NUM_REQ-1, all counters 0.
- Reset asserted mid-SHOW forces reset values immediately (asynchronous). The first grant after release follows the reset pointer.

## Timing
- `req` sampled high in IDLE at edge k: `grant` and `busy` are valid after edge k (1-cycle latency).
- The first PWM-driven LED level is valid after edge k+1, because the LED output register adds 1 cycle.
- Release via GAP: `grant` is 0 for exactly one cycle. The next `grant` is valid after the following edge.
- Minimum grant length is HOLD_CYC cycles unless the requester drops `req` earlier.
- `color` changes reach the LED pins 1 cycle after sampling.

## Configuration
- `RGB_LED_ARB_GAMMA_EN` defined:
  - Effective duty = (d*d) >> PWM_BITS, computed combinationally before the compare.
  - At 8 bits: d = 255 → 254, d = 128 → 64, d = 15 → 0.
- Undefined: effective duty = d (linear).
- Arbitration and timing are identical in both builds.

## Structure
- Package `rgb_led_arb_pkg` holds:
  - the state enum (IDLE, SHOW, GAP);
  - the `rgb_t` struct {r, g, b} of PWM_BITS each;
  - the HOLD_CYC / BLINK_CYC computation functions.
- Sub-module `led_pwm`: PWM counter, optional gamma, three comparators, blink gating and the output register.
- The arbiter FSM stays in `rgb_led_arbiter`.

## Test plan
Bench parameters: CLK_HZ=1000, HOLD_MS=4, BLINK_MS=2, giving HOLD_CYC=4 and BLINK_CYC=2. Gamma is off unless stated.
1. Single requester: req=0001 with color0 R=255, G=0, B=0 held → grant=0001 one cycle later and held indefinitely. `led_red_n` is low 255 of 256 cycles; green and blue stay 1.
2. Round-robin: req=1111 held from reset → grant sequence 0001, 0010, 0100, 1000, 0001, each for 4 cycles with a 1-cycle all-zero gap between.
3. Early drop: req0 high 2 cycles then low, req2 high → grant0 for 2 cycles, 1 gap cycle, then grant=0100.
4. Blink: req1 only, blink1=1, color all 255 → LEDs on 2 cycles, forced off 2 cycles, repeating; the phase restarts ON at each new grant.
5. Reset mid-SHOW: assert `rst_n`=0 asynchronously during grant=0100 → grant=0 and all LED outputs 1 immediately. After release with req=1111 → grant=0001 first.
6. `RGB_LED_ARB_GAMMA_EN` build: duty 128 → channel on 64 of 256 cycles; duty 255 → on 254 of 256 cycles.
